// File: rtl/score_display_pkg.sv
// Shared types and seven-segment constants for the score display path.
// Segment encodings are active-low, ordered {g,f,e,d,c,b,a}.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entries 10-15 are not valid BCD digits and decode to blank.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

  function automatic logic [6:0] idle_seg(input logic is_lsd, input logic blank_lz);
    return (is_lsd || !blank_lz) ? SEG_TABLE[0] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Bundle between the score counter (master) and the display block (slave).
interface score_display_if #(
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned NUM_DIGITS = 4
);

  logic [SCORE_W-1:0]      score;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [7*NUM_DIGITS-1:0] hex;
  logic                    overflow;
  logic                    busy;
  logic                    update;

  modport master (
    output score,
    input  bcd, hex, overflow, busy, update
  );

  modport slave (
    input  score,
    output bcd, hex, overflow, busy, update
  );

endinterface

// File: rtl/score_display_seg7_decoder.sv
// One digit of active-low seven-segment decode; dash wins over blank.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/score_display.sv
// Samples the binary score, converts it to BCD one double-dabble shift per
// cycle, and registers BCD, segment and overflow outputs on completion.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned MAX_SCORE  = 9999,
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  score_display_if.slave bus
);

  localparam int unsigned SCORE_W = $clog2(MAX_SCORE);
  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned HEX_W   = 7 * NUM_DIGITS;
  localparam int unsigned SR_W    = BCD_W + SCORE_W;
  localparam int unsigned CNT_W   = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

  function automatic logic [HEX_W-1:0] hex_reset();
    logic [HEX_W-1:0] h;
    h = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      h[7*i +: 7] = idle_seg(i == 0, BLANK_LZ);
    end
    return h;
  endfunction

  localparam logic [HEX_W-1:0] HEX_RST = hex_reset();

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SR_W-1:0]    shreg;
  logic [SR_W-1:0]    adj;
  logic               carry;
  logic [SCORE_W-1:0] score_i;
  logic [SCORE_W-1:0] cap;
  logic [SCORE_W-1:0] last;

  logic [BCD_W-1:0]      bcd_q;
  logic [HEX_W-1:0]      hex_q;
  logic                  ovf_q;
  logic                  busy_q;
  logic                  update_q;

  logic [BCD_W-1:0]      raw;
  logic [BCD_W-1:0]      dig_bcd;
  logic [NUM_DIGITS-1:0] dig_blank;
  logic [HEX_W-1:0]      seg_n;
  logic                  hi_zero;

  assign score_i      = bus.score;
  assign bus.bcd      = bcd_q;
  assign bus.hex      = hex_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.update   = update_q;

  always_comb begin
    adj = shreg;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (shreg[SCORE_W + 4*i +: 4] >= 4'd5) begin
        adj[SCORE_W + 4*i +: 4] = shreg[SCORE_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Blanking walks from the most significant digit down; digit 0 always shows.
  always_comb begin
    raw       = shreg[SR_W-1 -: BCD_W];
    dig_bcd   = '0;
    dig_blank = '0;
    hi_zero   = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_bcd[4*i +: 4] = carry ? 4'd9 : raw[4*i +: 4];
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      hi_zero = hi_zero && (raw[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      dig_blank[NUM_DIGITS-1-k] = BLANK_LZ && hi_zero && (k != NUM_DIGITS-1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .digit (dig_bcd[4*g +: 4]),
      .blank (dig_blank[g]),
      .dash  (carry),
      .seg   (seg_n[7*g +: 7])
    );
  end

  // Bits pushed out of the top nibble form the missing extra digit, so a
  // sticky carry flags any score beyond NUM_DIGITS decimal digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      carry    <= 1'b0;
      cap      <= '0;
      last     <= '0;
      bcd_q    <= '0;
      hex_q    <= HEX_RST;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state)
        IDLE: begin
          if (score_i != last) begin
            cap    <= score_i;
            shreg  <= {{BCD_W{1'b0}}, score_i};
            cnt    <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {adj[SR_W-2:0], 1'b0};
          carry <= carry | adj[SR_W-1];
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_q    <= dig_bcd;
          hex_q    <= seg_n;
          ovf_q    <= carry;
          last     <= cap;
          update_q <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: vector table plus hand-built
// sequences, with expected results queued and matched on each update pulse.
module tb_score_display;

  typedef struct {
    logic [13:0] score;
    logic [15:0] bcd;
    logic [27:0] hex;
    logic        ovf;
  } vec_t;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
  localparam logic [6:0] SB = 7'h7F, SD = 7'h3F;
  localparam logic [27:0] HEX_IDLE = {SB, SB, SB, S0};
  localparam logic [27:0] HEX_DASH = {SD, SD, SD, SD};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned upd_cnt = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  score_display_if #(.SCORE_W(14), .NUM_DIGITS(4)) bus ();

  score_display #(
    .MAX_SCORE  (9999),
    .NUM_DIGITS (4),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [13:0] s, input logic [15:0] b,
                              input logic [27:0] h, input logic o);
    vec_t v;
    v.score = s;
    v.bcd   = b;
    v.hex   = h;
    v.ovf   = o;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.update) begin
      vec_t e;
      upd_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: bcd=%h with no pending conversion", bus.bcd);
      end else begin
        e = exp_q.pop_front();
        if (bus.bcd !== e.bcd) begin
          errors++;
          $display("FAIL bcd(score=%0d): got %h required %h", e.score, bus.bcd, e.bcd);
        end
        checks++;
        if (bus.hex !== e.hex) begin
          errors++;
          $display("FAIL hex(score=%0d): got %h required %h", e.score, bus.hex, e.hex);
        end
        checks++;
        if (bus.overflow !== e.ovf) begin
          errors++;
          $display("FAIL overflow(score=%0d): got %b required %b", e.score, bus.overflow, e.ovf);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_update(score=%0d): got %b required 0", e.score, bus.busy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_bcd"}, 32'(bus.bcd), 32'h0);
    check({name, "_hex"}, 32'(bus.hex), 32'(HEX_IDLE));
    check({name, "_busy"}, 32'(bus.busy), 32'h0);
    check({name, "_update"}, 32'(bus.update), 32'h0);
    check({name, "_overflow"}, 32'(bus.overflow), 32'h0);
  endtask

  initial begin
    int unsigned k;
    int unsigned busy_n;
    int unsigned u0;

    tbl[0] = mk(14'd9999,  16'h9999, {S9, S9, S9, S9}, 1'b0);
    tbl[1] = mk(14'd0,     16'h0000, HEX_IDLE,         1'b0);
    tbl[2] = mk(14'd12000, 16'h9999, HEX_DASH,         1'b1);
    tbl[3] = mk(14'd42,    16'h0042, {SB, SB, S4, S2}, 1'b0);
    tbl[4] = mk(14'd10000, 16'h9999, HEX_DASH,         1'b1);
    tbl[5] = mk(14'd1000,  16'h1000, {S1, S0, S0, S0}, 1'b0);
    tbl[6] = mk(14'd105,   16'h0105, {SB, S1, S0, S5}, 1'b0);
    tbl[7] = mk(14'd16383, 16'h9999, HEX_DASH,         1'b1);
    tbl[8] = mk(14'd7006,  16'h7006, {S7, S0, S0, S6}, 1'b0);
    tbl[9] = mk(14'd60,    16'h0060, {SB, SB, S6, S0}, 1'b0);

    bus.score = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_reset_outputs("idle_zero");
    check("no_update_at_zero", upd_cnt, 0);

    // 0 -> 1234: latency and busy window
    bus.score = 14'd1234;
    exp_q.push_back(mk(14'd1234, 16'h1234, {S1, S2, S3, S4}, 1'b0));
    @(posedge clk);
    #1;
    k = 0;
    busy_n = 0;
    while (!bus.update && k < 40) begin
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      k++;
    end
    check("latency_edges", k, 15);
    check("busy_cycles", busy_n, 15);
    drain("c1234", 40);

    for (int i = 0; i < 10; i++) begin
      bus.score = tbl[i].score;
      exp_q.push_back(tbl[i]);
      drain($sformatf("vec%0d", i), 40);
    end

    // 60 -> 5, then 7 arrives three cycles into the conversion
    u0 = upd_cnt;
    bus.score = 14'd5;
    exp_q.push_back(mk(14'd5, 16'h0005, {SB, SB, SB, S5}, 1'b0));
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    bus.score = 14'd7;
    exp_q.push_back(mk(14'd7, 16'h0007, {SB, SB, SB, S7}, 1'b0));
    drain("mid_change", 80);
    repeat (20) @(posedge clk);
    #1;
    check("mid_change_pulses", upd_cnt - u0, 2);

    // reset during SHIFT with cnt == 6 on a 0 -> 321 conversion
    bus.score = 14'd0;
    exp_q.push_back(mk(14'd0, 16'h0000, HEX_IDLE, 1'b0));
    drain("to_zero", 40);
    u0 = upd_cnt;
    bus.score = 14'd321;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("no_update_from_abort", upd_cnt - u0, 0);
    exp_q.push_back(mk(14'd321, 16'h0321, {SB, S3, S2, S1}, 1'b0));
    drain("after_abort", 40);
    check("after_abort_pulses", upd_cnt - u0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
